// File: rtl/mult_div_unit_if.sv
// EXE-stage multiply/divide port: EXE drives requests (master), the HI/LO unit answers (slave).
interface mult_div_unit_if;
    logic        md_valid_in;
    logic [5:0]  md_op_in;
    logic [31:0] md_in0_in;
    logic [31:0] md_in1_in;
    logic        md_read_request_in;
    logic        md_read_sel_in;
    logic        md_flush_in;
    logic        md_busy_out;
    logic        md_stall_out;
    logic [31:0] md_rdata_out;
    logic [31:0] md_hi_out;
    logic [31:0] md_lo_out;

    modport master (
        output md_valid_in, md_op_in, md_in0_in, md_in1_in,
               md_read_request_in, md_read_sel_in, md_flush_in,
        input  md_busy_out, md_stall_out, md_rdata_out, md_hi_out, md_lo_out
    );

    modport slave (
        input  md_valid_in, md_op_in, md_in0_in, md_in1_in,
               md_read_request_in, md_read_sel_in, md_flush_in,
        output md_busy_out, md_stall_out, md_rdata_out, md_hi_out, md_lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: 32-step restoring divider, shift-add multiplier.
// Define MD_FAST_MUL_EN for a single-cycle combinational multiply instead.
module mult_div_unit (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  md
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
    } op_t;

    state_t      state, state_nxt;
    op_t         op;
    logic [31:0] hi, lo;
    logic [31:0] opnd;               // divisor or multiplicand magnitude
    logic [31:0] acc_hi, acc_lo;     // {rem, quo} or {product hi, product lo}
    logic [5:0]  cnt;
    logic        q_neg, r_neg;

    logic        busy, stall, accept, last_step;
    logic        is_signed, op_neg;
    logic [31:0] mag0, mag1;

    // Illegal multi-bit codes resolve to the lowest set bit.
    always_comb begin
        op = OP_NONE;
        if      (md.md_op_in[0]) op = OP_MULT;
        else if (md.md_op_in[1]) op = OP_MULTU;
        else if (md.md_op_in[2]) op = OP_DIV;
        else if (md.md_op_in[3]) op = OP_DIVU;
        else if (md.md_op_in[4]) op = OP_MTHI;
        else if (md.md_op_in[5]) op = OP_MTLO;
    end

    assign busy      = (state != IDLE);
    assign stall     = md.md_valid_in & (|md.md_op_in | md.md_read_request_in) & busy;
    assign accept    = md.md_valid_in & ~md.md_flush_in & ~stall & (op != OP_NONE);
    assign last_step = (cnt == 6'd31);

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_neg    = is_signed & (md.md_in0_in[31] ^ md.md_in1_in[31]);
    assign mag0      = (is_signed && md.md_in0_in[31]) ? -md.md_in0_in : md.md_in0_in;
    assign mag1      = (is_signed && md.md_in1_in[31]) ? -md.md_in1_in : md.md_in1_in;

    // Restoring divide step on the shifted {rem, quo} pair.
    logic [32:0] rem_sh;
    logic        no_borrow;
    logic [31:0] div_rem_nxt, div_quo_nxt, quo_fix, rem_fix;

    assign rem_sh      = {acc_hi, acc_lo[31]};
    assign no_borrow   = (rem_sh >= {1'b0, opnd});
    assign div_rem_nxt = no_borrow ? 32'(rem_sh - {1'b0, opnd}) : rem_sh[31:0];
    assign div_quo_nxt = {acc_lo[30:0], no_borrow};
    assign quo_fix     = q_neg ? -div_quo_nxt : div_quo_nxt;
    assign rem_fix     = r_neg ? -div_rem_nxt : div_rem_nxt;

`ifdef MD_FAST_MUL_EN
    logic [63:0] fast_prod, fast_fix;

    assign fast_prod = {32'b0, mag0} * {32'b0, mag1};
    assign fast_fix  = op_neg ? -fast_prod : fast_prod;
`else
    // Shift-add step: add the multiplicand when the low multiplier bit is set, then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_prod_nxt, mul_fix;

    assign mul_sum      = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
    assign mul_prod_nxt = {mul_sum[32:1], mul_sum[0], acc_lo[31:1]};
    assign mul_fix      = q_neg ? -mul_prod_nxt : mul_prod_nxt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state gets its default first so no path through the block can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op == OP_DIV || op == OP_DIVU) state_nxt = DIV;
`ifndef MD_FAST_MUL_EN
                    else if (op == OP_MULT || op == OP_MULTU) state_nxt = MUL;
`endif
                end
            end
            MUL, DIV: begin
                if (md.md_flush_in || last_step) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: hi <= md.md_in0_in;
                            OP_MTLO: lo <= md.md_in0_in;
                            OP_DIV, OP_DIVU: begin
                                opnd   <= mag1;
                                acc_hi <= '0;
                                acc_lo <= mag0;
                                cnt    <= '0;
                                q_neg  <= op_neg;
                                r_neg  <= is_signed & md.md_in0_in[31];
                            end
                            OP_MULT, OP_MULTU: begin
`ifdef MD_FAST_MUL_EN
                                {hi, lo} <= fast_fix;
`else
                                opnd   <= mag0;
                                acc_hi <= '0;
                                acc_lo <= mag1;
                                cnt    <= '0;
                                q_neg  <= op_neg;
                                r_neg  <= 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                DIV: begin
                    if (!md.md_flush_in) begin
                        acc_hi <= div_rem_nxt;
                        acc_lo <= div_quo_nxt;
                        cnt    <= cnt + 6'd1;
                        if (last_step) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                    end
                end
`ifndef MD_FAST_MUL_EN
                MUL: begin
                    if (!md.md_flush_in) begin
                        {acc_hi, acc_lo} <= mul_prod_nxt;
                        cnt              <= cnt + 6'd1;
                        if (last_step) {hi, lo} <= mul_fix;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign md.md_busy_out  = busy;
    assign md.md_stall_out = stall;
    assign md.md_rdata_out = md.md_read_sel_in ? hi : lo;
    assign md.md_hi_out    = hi;
    assign md.md_lo_out    = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops against an arithmetic HI/LO model;
// MFHI/MFLO data is checked by a scoreboard monitor.
module tb_mult_div_unit;
    logic clk;
    logic rst;

    mult_div_unit_if md();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read that is presented and not stalled returns data this cycle.
    always @(negedge clk) begin
        if (!rst && md.md_valid_in && md.md_read_request_in && !md.md_stall_out) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_read", md.md_rdata_out, 32'hxxxx_xxxx);
            end else begin
                check("sb_rdata", md.md_rdata_out, sb_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        md.md_valid_in        = 1'b0;
        md.md_op_in           = '0;
        md.md_in0_in          = '0;
        md.md_in1_in          = '0;
        md.md_read_request_in = 1'b0;
        md.md_read_sel_in     = 1'b0;
        md.md_flush_in        = 1'b0;
    endtask

    // Present one request; hold it until a non-stalled cycle, then release after the accept edge.
    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rd, input logic sel, input bit sync, output int stalls);
        bit done = 0;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        md.md_valid_in        = 1'b1;
        md.md_op_in           = op;
        md.md_in0_in          = a;
        md.md_in1_in          = b;
        md.md_read_request_in = rd;
        md.md_read_sel_in     = sel;
        stalls = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!md.md_stall_out) done = 1;
            else                  stalls++;
        end
        if (!done) check("stall_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_busy(output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (md.md_busy_out) n++;
            else                done = 1;
        end
        if (!done) check("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic read_reg(input logic sel);
        int st;
        sb_q.push_back(sel ? ref_hi : ref_lo);
        drive(6'b0, '0, '0, 1'b1, sel, 1'b1, st);
    endtask

    function automatic int lowest_op(input logic [5:0] op);
        for (int i = 0; i < 6; i++) if (op[i]) return i;
        return -1;
    endfunction

    function automatic int exp_busy(input logic [5:0] op);
        case (lowest_op(op))
            0, 1:    return MUL_LAT;
            2, 3:    return DIV_LAT;
            default: return 0;
        endcase
    endfunction

    // Architectural HI/LO result of one accepted op, from plain 64-bit arithmetic.
    task automatic ref_apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (lowest_op(op))
            0: begin
                p = 64'(sa * sb);
                {ref_hi, ref_lo} = p;
            end
            1: begin
                p = {32'b0, a} * {32'b0, b};
                {ref_hi, ref_lo} = p;
            end
            2: begin
                if (b == 0) begin
                    ref_lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    ref_hi = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_lo = q[31:0];
                    ref_hi = r[31:0];
                end
            end
            3: begin
                if (b == 0) begin
                    ref_lo = 32'hFFFF_FFFF;
                    ref_hi = a;
                end else begin
                    ref_lo = a / b;
                    ref_hi = a % b;
                end
            end
            4: ref_hi = a;
            5: ref_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int st, nb;
        drive(op, a, b, 1'b0, 1'b0, 1'b1, st);
        check("op_stall", 32'(st), 32'd0);
        wait_busy(nb);
        check("busy_cycles", 32'(nb), 32'(exp_busy(op)));
        ref_apply(op, a, b);
        check("hi_out", md.md_hi_out, ref_hi);
        check("lo_out", md.md_lo_out, ref_lo);
        read_reg(1'b1);
        read_reg(1'b0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int st, nb;
        logic [5:0] rop;

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy",  32'(md.md_busy_out),  32'd0);
        check("rst_stall", 32'(md.md_stall_out), 32'd0);
        check("rst_rdata", md.md_rdata_out, 32'd0);
        check("rst_hi",    md.md_hi_out, 32'd0);
        check("rst_lo",    md.md_lo_out, 32'd0);

        run_op(6'b000100, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_lo", md.md_lo_out, 32'hFFFF_FFFD);
        check("div_m7_hi", md.md_hi_out, 32'hFFFF_FFFF);
        run_op(6'b001000, 32'd7, 32'd0);
        check("divu_by0_lo", md.md_lo_out, 32'hFFFF_FFFF);
        check("divu_by0_hi", md.md_hi_out, 32'h0000_0007);
        run_op(6'b000001, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi", md.md_hi_out, 32'hFFFF_FFFF);
        check("mult_lo", md.md_lo_out, 32'hFFFF_FFFE);
        run_op(6'b000010, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi", md.md_hi_out, 32'h0000_0001);
        check("multu_lo", md.md_lo_out, 32'hFFFF_FFFE);
        run_op(6'b001100, 32'hFFFF_FFF9, 32'd2);
        check("illegal_is_div", md.md_lo_out, 32'hFFFF_FFFD);
        run_op(6'b000100, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush aborts a divide in its tenth busy cycle.
        run_op(6'b100000, 32'h0000_1234, 32'd0);
        drive(6'b001000, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, st);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy_before_flush", 32'(md.md_busy_out), 32'd1);
        md.md_flush_in = 1'b1;
        @(posedge clk);
        #1;
        md.md_flush_in = 1'b0;
        @(negedge clk);
        check("busy_after_flush", 32'(md.md_busy_out), 32'd0);
        check("lo_kept_on_flush", md.md_lo_out, 32'h0000_1234);
        run_op(6'b010000, 32'h0000_0055, 32'd0);

        // MFLO in the cycle right after a DIVU accept stalls for the whole divide.
        drive(6'b001000, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, st);
        ref_apply(6'b001000, 32'd100, 32'd7);
        sb_q.push_back(32'h0000_000E);
        drive(6'b0, '0, '0, 1'b1, 1'b0, 1'b0, st);
        check("mflo_stall_cycles", 32'(st), 32'd32);
        check("divu_hi", md.md_hi_out, 32'h0000_0002);

        // An op arriving during busy waits for the divide, then is accepted.
        drive(6'b001000, 32'd1000, 32'd9, 1'b0, 1'b0, 1'b1, st);
        ref_apply(6'b001000, 32'd1000, 32'd9);
        drive(6'b010000, 32'h0000_ABCD, '0, 1'b0, 1'b0, 1'b0, st);
        ref_apply(6'b010000, 32'h0000_ABCD, '0);
        check("op_stall_cycles", 32'(st), 32'd32);
        wait_busy(nb);
        check("mthi_after_busy_idle", 32'(nb), 32'd0);
        read_reg(1'b1);
        read_reg(1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(1, 63));
            else                            rop = 6'(1 << $urandom_range(0, 5));
            run_op(rop, rand_val(), rand_val());
        end

        // Asynchronous reset in the middle of a divide.
        run_op(6'b010000, 32'hDEAD_BEEF, 32'd0);
        drive(6'b000100, 32'h1234_5678, 32'd3, 1'b0, 1'b0, 1'b1, st);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",  32'(md.md_busy_out), 32'd0);
        check("midrst_hi",    md.md_hi_out, 32'd0);
        check("midrst_lo",    md.md_lo_out, 32'd0);
        check("midrst_rdata", md.md_rdata_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_hi = '0;
        ref_lo = '0;
        wait_busy(nb);
        check("post_rst_busy", 32'(nb), 32'd0);
        read_reg(1'b1);
        read_reg(1'b0);

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

HI/LO multiply/divide unit for the five-stage MIPS pipeline. It is the consumer side of the EXE-stage multiply/divide port: it receives operation codes, two operands and read requests, and runs a multi-cycle restoring divider and an optional iterative multiplier. It owns the architectural HI/LO registers, returns HI or LO data for MFHI/MFLO, and tells EXE when to stall.

## Interface

Parameters:
- None.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `md_valid_in`  in  1  EXE holds a valid, non-excepting instruction that presents `md_op_in` or `md_read_request_in`.
- `md_op_in`  in  6  bit 0 MULT, bit 1 MULTU, bit 2 DIV, bit 3 DIVU, bit 4 MTHI, bit 5 MTLO. All zero means no operation.
- `md_in0_in`  in  32  rs operand (dividend, multiplicand, or MTHI/MTLO data).
- `md_in1_in`  in  32  rt operand (divisor or multiplier).
- `md_read_request_in`  in  1  MFHI/MFLO read.
- `md_read_sel_in`  in  1  read select: 0 = LO, 1 = HI.
- `md_flush_in`  in  1  pipeline flush (exception or ERET at WB).
- `md_busy_out`  out  1  unit is iterating; high whenever state ≠ IDLE.
- `md_stall_out`  out  1  EXE must hold. Equals `md_valid_in & (|md_op_in | md_read_request_in) & md_busy_out`.
- `md_rdata_out`  out  32  combinational: `md_read_sel_in ? HI : LO`.
- `md_hi_out`, `md_lo_out`  out  32  current HI and LO values.

## Operation

- States: IDLE, MUL, DIV.
- Accept condition: `md_valid_in & ~md_flush_in & ~md_stall_out` with a nonzero op.
  - If more than one op bit is set (illegal), the lowest index wins.
- MTHI / MTLO: write HI or LO at the accept edge. No state change.
- DIV / DIVU on accept:
  - Latch the magnitudes of the operands (DIVU takes them as-is) and a 6-bit counter = 0.
  - Latch the quotient sign (in0[31]^in1[31]) and the remainder sign (in0[31]), both for DIV only.
  - Go to DIV.
- DIV state: one restoring step per cycle.
  - Shift the {rem, quo} pair left by one.
  - Trial-subtract the divisor from rem; if there is no borrow, keep the difference and set quo[0].
  - On the step where counter = 31, write LO = signed-fixed quotient and HI = signed-fixed remainder in the same edge, then go to IDLE.
- Divide by zero needs no special case: raw quotient = 0xFFFFFFFF, raw remainder = |dividend|, then the sign fix applies. No exception is raised.
- MULT / MULTU: same magnitude and sign handling as division. A 64-bit product is written as {HI, LO}.
- Flush while in MUL or DIV: abort, return to IDLE on the next edge, leave HI/LO unchanged. An op presented in the same cycle as the flush is not accepted.
- Reads: `md_rdata_out` is valid whenever `md_stall_out` is low. A read never changes state.

## Timing

- Reset values: state IDLE, HI = 0, LO = 0, counter = 0; `md_busy_out` = 0, `md_stall_out` = 0, `md_rdata_out` = 0.
- Divide, accept at edge T:
  - `md_busy_out` is high for cycles T+1 to T+32 (exactly 32 cycles).
  - HI/LO are updated at edge T+32.
  - A dependent read in cycle T+33 sees the new value.
- Multiply without the macro: same 32-cycle timing as divide.
- Multiply with the macro: HI/LO are written at edge T and busy never rises.
- A second op or read during busy stalls until the cycle after busy falls, then is accepted.
- Reset mid-operation: immediate return to the reset values.

## Configuration

- `MD_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational 32×32 signed/unsigned multiply written at the accept edge.
  - MUL state is unreachable.
- Not defined:
  - Radix-2 shift-add on the magnitudes, one multiplier bit per cycle, 32 cycles.
  - Sign fix and write-back on the last step.

## Test plan

- Reset with `rst` pulsed mid-DIV -> HI = LO = 0, `md_busy_out` = 0 immediately; `md_rdata_out` = 0.
- DIV in0 = 0xFFFFFFF9 (−7), in1 = 2 -> busy for exactly 32 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU in0 = 7, in1 = 0 -> LO = 0xFFFFFFFF, HI = 0x00000007.
- MULT 0xFFFFFFFF × 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU with the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE. Run with and without `MD_FAST_MUL_EN` and check the 0- vs 32-cycle busy.
- MTLO 0x1234 first, then DIVU 100/7 with `md_flush_in` pulsed in busy cycle 10 -> busy falls next cycle, LO remains 0x1234; a following MTHI 0x55 is accepted immediately.
- MFLO (sel = 0) issued at T+1 of DIVU 100/7 -> `md_stall_out` high through T+32; at T+33 `md_rdata_out` = 0x0000000E, and HI = 0x00000002.
